// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer, synchronous flush and bubble payload.
// Optional stall/bubble performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid #(
    parameter int                DATA_W   = 128,
    parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_dn_valid;
    logic              r_up_ready;
    logic              w_up_fire;
    logic              w_dn_fire;

    // Next-state and next-payload selection; flush overrides any handshake.
    always_comb begin
        w_up_fire   = up_valid & r_up_ready;
        w_dn_fire   = r_dn_valid & dn_ready;
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_DATA;
            w_skid_nxt  = NOP_DATA;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_up_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = up_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_up_fire && w_dn_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = up_data;
                    end else if (w_up_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = up_data;
                    end else if (w_dn_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = NOP_DATA;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // The older entry sits in main, so draining promotes skid forward.
                    if (w_dn_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid_data;
                        w_skid_nxt  = NOP_DATA;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = NOP_DATA;
                    w_skid_nxt  = NOP_DATA;
                end
            endcase
        end
    end

    // State and storage registers; handshake outputs are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= NOP_DATA;
            r_skid_data <= NOP_DATA;
            r_dn_valid  <= 1'b0;
            r_up_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
            r_dn_valid  <= (w_state_nxt != ST_EMPTY);
            r_up_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    assign up_ready  = r_up_ready;
    assign dn_valid  = r_dn_valid;
    assign dn_data   = r_main_data;
    assign occupancy = r_state;

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; only rst clears them so they survive flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= {CNT_W{1'b0}};
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            if (r_dn_valid && !dn_ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (!r_dn_valid) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = {CNT_W{1'b0}};
`endif

endmodule
